// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Hazard controller for the register file of the 5-stage pipeline.
// Keeps the destinations of in-flight variable-latency loads in an
// in-order queue plus a per-register pending bitmap. From these it stalls
// l2 on RAW/WAW hazards and on a full queue, drives the operand forward
// selects for l2, and arbitrates the single regfile write port between ALU
// writeback and load-response writeback.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   issue_valid_l2, flush_l2  l2 instruction wants to advance / is squashed
//   rs1_l2, rs2_l2            l2 source registers, use_rs*_l2 = actually read
//   rd_l2, wen_l2, load_l2    l2 destination, writes-rd flag, is-load flag
//   alu_rd_l3, alu_wen_l3     ALU writeback request this cycle
//   ram_rvalid / ram_rready   load response handshake (oldest load first)
//   stall_l2                  hold l2 this cycle
//   fwd1_sel_l2, fwd2_sel_l2  0 regfile, 1 alu_q_l3, 2 ram_rdata_l3
//   rd_l3, load_l3            regfile write address (0 = none), data select
//   lq_count, lq_empty        outstanding loads
module regfile_scoreboard #(
    parameter int LQ_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      issue_valid_l2,
    input  logic                      flush_l2,
    input  logic [4:0]                rs1_l2,
    input  logic [4:0]                rs2_l2,
    input  logic                      use_rs1_l2,
    input  logic                      use_rs2_l2,
    input  logic [4:0]                rd_l2,
    input  logic                      wen_l2,
    input  logic                      load_l2,
    input  logic [4:0]                alu_rd_l3,
    input  logic                      alu_wen_l3,
    input  logic                      ram_rvalid,
    output logic                      ram_rready,
    output logic                      stall_l2,
    output logic [1:0]                fwd1_sel_l2,
    output logic [1:0]                fwd2_sel_l2,
    output logic [4:0]                rd_l3,
    output logic                      load_l3,
    output logic [$clog2(LQ_DEPTH):0] lq_count,
    output logic                      lq_empty
);

    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    lq_mem_r [LQ_DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;
    // Bit 0 is never set: x0 is never a hazard.
    logic [31:0]   pending_r;

    logic          alu_busy_s;
    logic          accept_s;
    logic          full_s;
    logic          fire_s;
    logic          push_s;
    logic [4:0]    head_rd_s;
    logic [4:0]    push_rd_s;
    logic [31:0]   clr_s;
    logic [31:0]   set_s;
    logic [31:0]   pend_eff_s;

    // Operand source priority: x0 always from regfile; a response accepted
    // this cycle and an ALU writeback never coincide (rready is low while
    // the ALU owns the port), so their order here is immaterial.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       acc,
        input logic [4:0] hrd,
        input logic       busy,
        input logic [4:0] ard
    );
        logic [1:0] sel;
        if (rs == 5'd0) begin
            sel = 2'd0;
        end else if (acc && (hrd == rs)) begin
            sel = 2'd2;
        end else if (busy && (ard == rs)) begin
            sel = 2'd1;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // Hazard detection, write-port arbitration and queue control.
    always_comb begin
        alu_busy_s  = alu_wen_l3 && (alu_rd_l3 != 5'd0);
        lq_empty    = (count_r == CW'(0));
        full_s      = (count_r == CW'(LQ_DEPTH));
        ram_rready  = !lq_empty && !alu_busy_s;
        accept_s    = ram_rvalid && ram_rready;
        head_rd_s   = lq_mem_r[head_r];
        clr_s       = 32'd0;
        if (accept_s) begin
            clr_s = 32'd1 << head_rd_s;
        end else begin
            clr_s = 32'd0;
        end
        // A response retiring this cycle already resolves its register.
        pend_eff_s  = pending_r & ~clr_s;
        // A full queue stalls a load even if a pop happens this cycle.
        stall_l2    = issue_valid_l2 &&
                      ((use_rs1_l2 && (rs1_l2 != 5'd0) && pend_eff_s[rs1_l2]) ||
                       (use_rs2_l2 && (rs2_l2 != 5'd0) && pend_eff_s[rs2_l2]) ||
                       (wen_l2     && (rd_l2  != 5'd0) && pend_eff_s[rd_l2])  ||
                       (load_l2    && full_s));
        fire_s      = issue_valid_l2 && !stall_l2 && !flush_l2;
        push_s      = fire_s && load_l2;
        // Loads without a destination still take an entry to consume
        // their response in order.
        push_rd_s   = wen_l2 ? rd_l2 : 5'd0;
        set_s       = 32'd0;
        if (push_s && (push_rd_s != 5'd0)) begin
            set_s = 32'd1 << push_rd_s;
        end else begin
            set_s = 32'd0;
        end
        fwd1_sel_l2 = fwd_sel(rs1_l2, accept_s, head_rd_s, alu_busy_s, alu_rd_l3);
        fwd2_sel_l2 = fwd_sel(rs2_l2, accept_s, head_rd_s, alu_busy_s, alu_rd_l3);
        load_l3     = accept_s;
        if (accept_s) begin
            rd_l3 = head_rd_s;
        end else if (alu_wen_l3) begin
            rd_l3 = alu_rd_l3;
        end else begin
            rd_l3 = 5'd0;
        end
        lq_count    = count_r;
    end

    // Load queue, pointers, occupancy and pending bitmap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_r    <= {PW{1'b0}};
            tail_r    <= {PW{1'b0}};
            count_r   <= {CW{1'b0}};
            pending_r <= 32'd0;
            for (int i = 0; i < LQ_DEPTH; i++) begin
                lq_mem_r[i] <= 5'd0;
            end
        end else begin
            if (push_s) begin
                lq_mem_r[tail_r] <= push_rd_s;
                tail_r           <= tail_r + PW'(1);
            end
            if (accept_s) begin
                head_r <= head_r + PW'(1);
            end
            case ({push_s, accept_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            // A same-cycle push may re-arm the register being retired.
            pending_r <= pend_eff_s | set_s;
        end
    end

endmodule
